// File: rtl/spi_lcd_rx_if.sv
// Read-side bus of spi_lcd_rx: FWFT head word, occupancy and status flags.
// slave = the receiver, master = whoever drains it.
interface spi_lcd_rx_if #(
    parameter int DEPTH = 16
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [8:0]    dout;
    logic          valid;
    logic          rd;
    logic          overflow;
    logic          ovf_clr;
    logic          frame_err;
    logic [CW-1:0] count;

    modport slave  (output dout, valid, overflow, frame_err, count,
                    input  rd, ovf_clr);
    modport master (input  dout, valid, overflow, frame_err, count,
                    output rd, ovf_clr);
endinterface

// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: 9-bit mode-0 SPI slave (D/C + 8 data) feeding a first-word-fall-through FIFO.
// Define SPI_LCD_RX_ECHO_EN to return the previously completed word on miso.
module spi_lcd_rx #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csn,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    spi_lcd_rx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   csn_prev_q, csn_prev_d;
    logic                   sck_prev_q, sck_prev_d;

    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          ferr_q, ferr_d;

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    dout_q, dout_d;
    logic          ovf_q, ovf_d;

    logic csn_s, sck_s, mosi_s;
    logic csn_fall, csn_rise, sck_rise;
    logic do_push, do_pop;

    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign csn_fall = csn_prev_q & ~csn_s;
    assign csn_rise = ~csn_prev_q & csn_s;
    assign sck_rise = ~sck_prev_q & sck_s;

    assign do_pop  = bus.rd && (count_q != '0);
    // A full FIFO still accepts a word when the same cycle pops one.
    assign do_push = push_q && ((count_q != FULL) || do_pop);

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch leaves one unassigned and no latch is inferred.
        csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], csn};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        csn_prev_d  = csn_s;
        sck_prev_d  = sck_s;

        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        push_d   = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            WAIT_IDLE: if (csn_s) state_d = IDLE;
            IDLE: begin
                if (csn_fall) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    shift_d = {shift_q[7:0], mosi_s};
                    if (bitcnt_q == 4'd8) begin
                        push_d   = 1'b1;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
                // bitcnt_d already includes a coincident 9th edge, which wraps it to 0.
                if (csn_rise) begin
                    ferr_d   = (bitcnt_d != '0);
                    bitcnt_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Next head word; the slot being written this cycle is not yet in mem_q.
        if (count_d == '0)
            dout_d = dout_q;
        else if (do_push && (rd_ptr_d == wr_ptr_q))
            dout_d = shift_q;
        else
            dout_d = mem_q[rd_ptr_d];

        ovf_d = (ovf_q & ~bus.ovf_clr) | (push_q & ~do_push);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout, so every flop samples the values from before this edge.
        if (rst) begin
            // Synchronisers clear to 0 so a csn held low through reset stays low to WAIT_IDLE.
            csn_sync_q  <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            csn_prev_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            state_q     <= WAIT_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            ferr_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            csn_sync_q  <= csn_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            csn_prev_q  <= csn_prev_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            ferr_q      <= ferr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: storage is deliberately not reset; dout is a separate registered copy, so stale entries never show.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.dout      = dout_q;
    assign bus.valid     = (count_q != '0);
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.frame_err = ferr_q;

`ifdef SPI_LCD_RX_ECHO_EN
    logic       sck_fall;
    logic [8:0] echo_q, echo_d;
    logic [8:0] last_q, last_d;

    assign sck_fall = sck_prev_q & ~sck_s;

    // Falls 1..8 of a word shift; the 9th fall sees bitcnt back at 0 and keeps the reload.
    always_comb begin
        echo_d = echo_q;
        last_d = last_q;
        if (push_q) begin
            last_d = shift_q;
            echo_d = shift_q;
        end else if (csn_fall) begin
            echo_d = last_q;
        end else if (sck_fall && !csn_s && (state_q == SHIFT) && (bitcnt_q != '0)) begin
            echo_d = {echo_q[7:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_q <= '0;
            last_q <= '0;
        end else begin
            echo_q <= echo_d;
            last_q <= last_d;
        end
    end

    assign miso = echo_q[8] & ~csn_s;
`else
    assign miso = 1'b0;
`endif
endmodule

// File: tb/tb_spi_lcd_rx.sv
// Self-checking bench for spi_lcd_rx: a queue scoreboard of expected FIFO words,
// popped and compared as the DUT presents them on its read port.
module tb_spi_lcd_rx;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic csn  = 1'b0;
    logic sck  = 1'b0;
    logic mosi = 1'b0;
    logic miso;

    spi_lcd_rx_if #(.DEPTH(DEPTH)) bus ();

    spi_lcd_rx #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk  (clk),
        .rst  (rst),
        .csn  (csn),
        .sck  (sck),
        .mosi (mosi),
        .miso (miso),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    int         cyc = 0;
    int         last_rise_cyc = 0;
    int         valid_rise_cyc = 0;
    logic       valid_prev = 1'b0;
    int         ferr_cnt = 0;
    logic       miso_hi = 1'b0;
    logic [8:0] miso_word;
    bit         alt_done;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid && !valid_prev) valid_rise_cyc <= cyc;
        valid_prev <= bus.valid;
        if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (miso !== 1'b0) miso_hi <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [8:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else exp_ovf = 1'b1;
    endtask

    // One mode-0 bit: data set while sck low, miso sampled just before the rising edge.
    task automatic spi_bit(input logic b, input int half, input bit rd_pulse, output logic ms);
        mosi = b;
        repeat (half) @(negedge clk);
        ms  = miso;
        sck = 1'b1;
        last_rise_cyc = cyc;
        if (rd_pulse) begin
            // Land rd on the cycle the DUT pushes the completed word.
            repeat (SYNC + 1) @(negedge clk);
            bus.rd = 1'b1;
            @(negedge clk);
            bus.rd = 1'b0;
            repeat (half - SYNC - 2) @(negedge clk);
        end else begin
            repeat (half) @(negedge clk);
        end
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [8:0] w, input int half, input bit rd_at_push);
        logic ms;
        for (int i = 8; i >= 0; i--) begin
            spi_bit(w[i], half, rd_at_push && (i == 0), ms);
            miso_word[i] = ms;
        end
        if (rd_at_push) begin
            void'(exp_q.pop_front());
            exp_q.push_back(w);
        end else begin
            sb_push(w);
        end
    endtask

    task automatic csn_low();
        csn = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic csn_high();
        repeat (4) @(negedge clk);
        csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic read_word(input string tag);
        int         n;
        logic [8:0] e;
        n = 0;
        while (!bus.valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus.valid, 1'b1);
        check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        e = 9'h0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check(tag, bus.dout, e);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ms;
        int   mx;
        bit   rd_tog;
        int   n;

        bus.rd      = 1'b0;
        bus.ovf_clr = 1'b0;

        // Reset held while a stream is already running with csn low.
        for (int i = 0; i < 3; i++) spi_bit(i[0], 4, 1'b0, ms);
        check("rst_dout", bus.dout, 9'h0);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_ferr", bus.frame_err, 1'b0);
        check("rst_count", bus.count, 0);
        check("rst_miso", miso, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) spi_bit(i[1], 4, 1'b0, ms);
        repeat (8) @(negedge clk);
        check("midstream_count", bus.count, 0);
        check("midstream_ferr", ferr_cnt, 0);
        csn = 1'b1;
        repeat (8) @(negedge clk);

        // First clean frame and its latency from the 9th sck rise.
        csn_low();
        send_word(9'h1A5, 4, 1'b0);
        csn_high();
        check("first_lat", (valid_rise_cyc - last_rise_cyc) <= SYNC + 3, 1'b1);
        check("first_count", bus.count, 1);
        read_word("first_word");
        check("first_empty", bus.valid, 1'b0);

        // Three words back to back under one csn low.
        csn_low();
        send_word(9'h02C, 4, 1'b0);
        send_word(9'h155, 4, 1'b0);
        send_word(9'h1FF, 4, 1'b0);
        csn_high();
        check("burst_count", bus.count, 3);
        for (int i = 0; i < 3; i++) read_word("burst_word");
        check("burst_empty", bus.valid, 1'b0);
        check("burst_ferr", ferr_cnt, 0);

        // Aborted frame after 5 bits, then a good frame.
        csn_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 4, 1'b0, ms);
        csn_high();
        check("abort_ferr", ferr_cnt, 1);
        check("abort_count", bus.count, 0);
        csn_low();
        send_word(9'h0AB, 4, 1'b0);
        csn_high();
        read_word("after_abort");

        // Overflow: DEPTH+1 words without reading.
        csn_low();
        for (int i = 0; i <= DEPTH; i++) send_word(9'((i * 37) + 5), 5, 1'b0);
        csn_high();
        check("full_count", bus.count, DEPTH);
        check("full_ovf", bus.overflow, exp_ovf);
        check("full_head", bus.dout, exp_q[0]);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", bus.overflow, 1'b0);

        // Push coinciding with a pop while full.
        csn_low();
        send_word(9'h0F0, 5, 1'b1);
        csn_high();
        check("coinc_count", bus.count, DEPTH);
        check("coinc_ovf", bus.overflow, 1'b0);
        for (int i = 0; i < DEPTH; i++) read_word("drain");
        check("drain_empty", bus.count, 0);

        // Streaming at the minimum clock ratio with rd toggling every cycle.
        alt_done = 1'b0;
        mx = 0;
        fork
            begin
                csn_low();
                send_word(9'h133, 2, 1'b0);
                send_word(9'h0CC, 2, 1'b0);
                send_word(9'h1E1, 2, 1'b0);
                send_word(9'h01E, 2, 1'b0);
                csn_high();
                alt_done = 1'b1;
            end
            begin
                rd_tog = 1'b0;
                n = 0;
                while (!alt_done && n < 5000) begin
                    @(negedge clk);
                    n++;
                    if (int'(bus.count) > mx) mx = int'(bus.count);
                    rd_tog = ~rd_tog;
                    bus.rd = rd_tog;
                    if (rd_tog && bus.valid) begin
                        check("alt_sb_nonempty", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) check("alt_word", bus.dout, exp_q.pop_front());
                    end
                end
                bus.rd = 1'b0;
            end
        join
        check("alt_done", alt_done, 1'b1);
        check("alt_max", mx <= 1, 1'b1);
        check("alt_left", exp_q.size(), 0);
        check("alt_count", bus.count, 0);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        @(negedge clk);
        check("rd_empty_count", bus.count, 0);

        // Readback on miso of the previously completed word.
        miso_hi = 1'b0;
        csn_low();
        send_word(9'h1C3, 5, 1'b0);
        csn_high();
        check("echo_idle_miso", miso, 1'b0);
        csn_low();
        send_word(9'h000, 5, 1'b0);
        csn_high();
`ifdef SPI_LCD_RX_ECHO_EN
        check("echo_bits", miso_word, 9'h1C3);
`else
        check("miso_zero", {miso_hi, miso_word}, 10'h0);
`endif
        read_word("echo_w0");
        read_word("echo_w1");
        check("ferr_total", ferr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_lcd_rx.md
Name: spi_lcd_rx

Overview:
- 9-bit SPI slave receiver. It is the far end of the LCD command link: it deserialises the csn/sck/mosi stream that the SPI master drives.
- Each frame carries one D/C bit followed by 8 data bits. Received words are buffered in an internal FWFT FIFO and presented on a valid/rd interface.
- Used as an on-chip loopback checker for the LCD path and as the bus-readable capture port of the LCD debug peripheral.

Parameters:
- DEPTH, 16, receive FIFO depth in words; power of 2, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on csn/sck/mosi; minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- csn  in  1  slave select, active low, asynchronous to clk.
- sck  in  1  SPI clock (mode 0, idle low), asynchronous to clk.
- mosi  in  1  serial data, MSB (D/C bit) first.
- miso  out  1  serial return data (see Optional Feature).
- dout  out  9  head-of-FIFO word; bit 8 = D/C (1 data, 0 command), bits 7:0 = payload.
- valid  out  1  dout holds a valid word (FIFO not empty).
- rd  in  1  pop head word; ignored when valid=0.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- frame_err  out  1  one-cycle pulse: csn deasserted with 1..8 bits received.
- count  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: dout=0, valid=0, overflow=0, frame_err=0, count=0, miso=0. FIFO pointers, bit counter and shifter are cleared.
- After reset the FSM is in WAIT_IDLE.
- Synchronisers: csn, sck and mosi each pass SYNC_STAGES flops. Edges are detected by comparing the last stage with one extra registered copy.
- Requirement: clk frequency >= 4 x sck frequency. Behaviour below that ratio is undefined.
- FSM states:
  - WAIT_IDLE: stays until synced csn=1, then -> IDLE. Resetting mid-frame therefore never yields a misaligned word.
  - IDLE: on csn falling edge -> SHIFT, bitcnt=0.
  - SHIFT: on each sck rising edge, shifter={shifter[7:0],mosi_sync} and bitcnt++.
    - When bitcnt reaches 9: assert push for one cycle, set bitcnt=0, stay in SHIFT. Back-to-back words are allowed under a single csn low.
    - On csn rising edge: if bitcnt in 1..8, pulse frame_err and discard the partial word. Then -> IDLE.
  - If a csn rising edge and the 9th sck rising edge are detected in the same cycle, the word is pushed and frame_err is not raised.
- sck edges while csn=1 are ignored.
- Latency: push occurs in the cycle after the 9th sck rising edge is detected. valid/dout update in the following cycle. The total from pin edge is <= SYNC_STAGES+3 clk cycles.
- FIFO: first-word-fall-through.
  - dout always shows the head word; dout is don't-care when valid=0 but holds its last value.
  - rd with valid=1 pops; the next word appears on dout the following cycle.
  - Push and pop in the same cycle: both occur and count is unchanged. This applies when full as well, so a word is not dropped in that case.
  - Push when full without pop: word dropped, overflow set to 1, FIFO contents unchanged.
  - ovf_clr and an overflow event in the same cycle: overflow stays 1.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Optional Feature:
- Macro: SPI_LCD_RX_ECHO_EN.
- Defined: miso returns the previously completed word MSB-first.
  - At each csn falling edge, and after every completed word, a 9-bit echo register loads the last pushed word (0 after reset).
  - Its MSB drives miso; the register shifts on each detected sck falling edge while csn=0.
  - miso=0 while csn=1.
  - This lets the SPI master verify the link by reading back.
- Undefined: miso is tied 0 and no echo logic is built.

Test Plan:
- Reset released with csn held low mid-stream -> no word pushed until csn goes high then low; first clean frame 1_0xA5 -> dout=0x1A5, valid=1 within SYNC_STAGES+3 cycles of the 9th sck rise.
- One csn-low burst of three words 0x02C, 0x155, 0x1FF -> count reaches 3; three rd pulses return them in order; valid=0 afterwards.
- Frame aborted after 5 bits -> frame_err pulses once, count unchanged; the next full frame 0x0AB is received correctly.
- DEPTH=16: send 17 words without rd -> count=16, overflow=1, dout=first word. ovf_clr -> overflow=0. Push coinciding with rd when full -> count stays 16, overflow stays 0.
- Alternating rd every cycle while words stream back to back -> no loss, count never exceeds 1; rd while valid=0 leaves count=0.
- With SPI_LCD_RX_ECHO_EN: send 0x1C3 then 0x000 -> miso during the second frame carries bits 1,1,1,0,0,0,0,1,1. Without the macro, miso stays 0 throughout.
